// File: rtl/knapsack_search_ctrl.sv
// Exhaustive 5-item knapsack sweep: one candidate per clock, feasible selections
// streamed under valid/ready, best selection and feasible count reported at the end.
module knapsack_search_ctrl #(
    parameter int N_ITEMS = 5,
    parameter int SUM_W   = 8,
    parameter logic [N_ITEMS*SUM_W-1:0] ITEM_VAL = {8'd10, 8'd1, 8'd2, 8'd2, 8'd4},
    parameter logic [N_ITEMS*SUM_W-1:0] ITEM_WT  = {8'd4,  8'd1, 8'd2, 8'd1, 8'd12}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SUM_W-1:0]   min_value,
    input  logic [SUM_W-1:0]   max_weight,
    output logic               busy,
    output logic               sol_valid,
    input  logic               sol_ready,
    output logic [N_ITEMS-1:0] sol_sel,
    output logic [SUM_W-1:0]   sol_value,
    output logic [SUM_W-1:0]   sol_weight,
    output logic               done_valid,
    input  logic               done_ready,
    output logic               best_found,
    output logic [N_ITEMS-1:0] best_sel,
    output logic [SUM_W-1:0]   best_value,
    output logic [SUM_W-1:0]   best_weight,
    output logic [N_ITEMS:0]   sol_count,
    output logic [1:0]         dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; the producer holds valid and payload stable until that edge.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [N_ITEMS-1:0] r_c;
    logic [SUM_W-1:0]   r_min;
    logic [SUM_W-1:0]   r_max;
    logic               r_sol_valid;
    logic [N_ITEMS-1:0] r_sol_sel;
    logic [SUM_W-1:0]   r_sol_value;
    logic [SUM_W-1:0]   r_sol_weight;
    logic               r_best_found;
    logic [N_ITEMS-1:0] r_best_sel;
    logic [SUM_W-1:0]   r_best_value;
    logic [SUM_W-1:0]   r_best_weight;
    logic [N_ITEMS:0]   r_count;

    logic [SUM_W-1:0]   w_value;
    logic [SUM_W-1:0]   w_weight;
    logic               w_feasible;
    logic               w_slot_free;
    logic               w_load;
    logic               w_advance;
    logic               w_better;

    always_comb begin
        w_value  = '0;
        w_weight = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (r_c[i]) begin
                w_value  = w_value  + ITEM_VAL[i*SUM_W +: SUM_W];
                w_weight = w_weight + ITEM_WT[i*SUM_W +: SUM_W];
            end
        end
    end

    assign w_feasible  = (w_value >= r_min) && (w_weight <= r_max);
    assign w_slot_free = !r_sol_valid || sol_ready;
    assign w_load      = (r_state == S_SCAN) && w_feasible && w_slot_free;
    // A feasible candidate that cannot be emitted stalls the sweep in place.
    assign w_advance   = (r_state == S_SCAN) && (!w_feasible || w_slot_free);
    // Strict comparisons keep the lower-index candidate on a full tie.
    assign w_better    = !r_best_found || (w_value > r_best_value) ||
                         ((w_value == r_best_value) && (w_weight < r_best_weight));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_SCAN;
            S_SCAN:  if (w_advance && (&r_c)) w_next_state = S_DRAIN;
            S_DRAIN: if (w_slot_free) w_next_state = S_DONE;
            S_DONE:  if (done_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c           <= '0;
            r_min         <= '0;
            r_max         <= '0;
            r_sol_valid   <= 1'b0;
            r_sol_sel     <= '0;
            r_sol_value   <= '0;
            r_sol_weight  <= '0;
            r_best_found  <= 1'b0;
            r_best_sel    <= '0;
            r_best_value  <= '0;
            r_best_weight <= '0;
            r_count       <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_min         <= min_value;
                r_max         <= max_weight;
                r_c           <= '0;
                r_best_found  <= 1'b0;
                r_best_sel    <= '0;
                r_best_value  <= '0;
                r_best_weight <= '0;
                r_count       <= '0;
            end
            if (w_advance) r_c <= r_c + 1'b1;
            if (w_load) begin
                r_sol_valid  <= 1'b1;
                r_sol_sel    <= r_c;
                r_sol_value  <= w_value;
                r_sol_weight <= w_weight;
                r_count      <= r_count + 1'b1;
                if (w_better) begin
                    r_best_found  <= 1'b1;
                    r_best_sel    <= r_c;
                    r_best_value  <= w_value;
                    r_best_weight <= w_weight;
                end
            end else if (sol_ready) begin
                r_sol_valid <= 1'b0;
            end
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done_valid  = (r_state == S_DONE);
    assign sol_valid   = r_sol_valid;
    assign sol_sel     = r_sol_sel;
    assign sol_value   = r_sol_value;
    assign sol_weight  = r_sol_weight;
    assign best_found  = r_best_found;
    assign best_sel    = r_best_sel;
    assign best_value  = r_best_value;
    assign best_weight = r_best_weight;
    assign sol_count   = r_count;
    assign dbg_state   = r_state;

endmodule
